// File: rtl/clock_7seg_scan_driver.sv
// Multiplexed six-digit HH:MM:SS 7-segment driver: binary time in, one lit digit
// per scan slot out, with 12h/24h mapping, leading-zero blanking and field blinking.
module clock_7seg_scan_driver #(
  parameter int SCAN_DIV       = 1000,
  parameter int BLINK_DIV      = 5000000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_en,
  input  logic [5:0] i_seconds,
  input  logic [5:0] i_minutes,
  input  logic [4:0] i_hours,
  input  logic       i_mode_12h,
  input  logic [1:0] i_blink_sel,
  output logic [6:0] o_seg,
  output logic [5:0] o_dig,
  output logic       o_pm
);

  localparam int SCAN_W  = ($clog2(SCAN_DIV) < 1) ? 1 : $clog2(SCAN_DIV);
  localparam int BLINK_W = ($clog2(BLINK_DIV) < 1) ? 1 : $clog2(BLINK_DIV);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_POL   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [5:0] DIG_POL   = DIG_ACTIVE_LOW ? 6'h3F : 6'h00;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HR   = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_of_digit = 7'h3F;
      4'd1:    seg_of_digit = 7'h06;
      4'd2:    seg_of_digit = 7'h5B;
      4'd3:    seg_of_digit = 7'h4F;
      4'd4:    seg_of_digit = 7'h66;
      4'd5:    seg_of_digit = 7'h6D;
      4'd6:    seg_of_digit = 7'h7D;
      4'd7:    seg_of_digit = 7'h07;
      4'd8:    seg_of_digit = 7'h7F;
      4'd9:    seg_of_digit = 7'h6F;
      default: seg_of_digit = SEG_DASH;
    endcase
  endfunction

  // Returns {tens, ones}. Ones is v - 10*tens taken modulo 16, which is exact
  // because the true remainder is always below 10.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] sub;
    if (v >= 6'd50) begin
      tens = 4'd5;
      sub  = 4'd2;
    end else if (v >= 6'd40) begin
      tens = 4'd4;
      sub  = 4'd8;
    end else if (v >= 6'd30) begin
      tens = 4'd3;
      sub  = 4'd14;
    end else if (v >= 6'd20) begin
      tens = 4'd2;
      sub  = 4'd4;
    end else if (v >= 6'd10) begin
      tens = 4'd1;
      sub  = 4'd10;
    end else begin
      tens = 4'd0;
      sub  = 4'd0;
    end
    to_bcd = {tens, v[3:0] - sub};
  endfunction

  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [2:0]         idx_r;
  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_vis_r;
  logic               first_r;
  logic [5:0]         sec_snap_r;
  logic [5:0]         min_snap_r;
  logic [4:0]         hr_snap_r;
  logic               mode_snap_r;
  logic [1:0]         blink_sel_snap_r;

  logic               scan_last_s;
  logic               frame_wrap_s;
  logic               sec_valid_s;
  logic               min_valid_s;
  logic               hr_valid_s;
  logic [4:0]         hr_disp_s;
  logic               pm_s;
  logic [7:0]         sec_bcd_s;
  logic [7:0]         min_bcd_s;
  logic [7:0]         hr_bcd_s;
  logic [6:0]         raw_seg_s;
  logic [1:0]         field_s;
  logic [6:0]         seg_s;
  logic [5:0]         dig_s;

  assign scan_last_s  = (scan_cnt_r == SCAN_LAST);
  assign frame_wrap_s = scan_last_s && (idx_r == 3'd5);

  // Scan prescaler, digit index and free-running blink phase.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      scan_cnt_r  <= SCAN_W'(0);
      idx_r       <= 3'd0;
      blink_cnt_r <= BLINK_W'(0);
      blink_vis_r <= 1'b1;
    end else begin
      if (scan_last_s) begin
        scan_cnt_r <= SCAN_W'(0);
        idx_r      <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
      end else begin
        scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
      end
      if (blink_cnt_r == BLINK_LAST) begin
        blink_cnt_r <= BLINK_W'(0);
        blink_vis_r <= ~blink_vis_r;
      end else begin
        blink_cnt_r <= blink_cnt_r + BLINK_W'(1);
      end
    end
  end

  // Per-frame input snapshot so one frame always shows a single coherent time.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      first_r          <= 1'b1;
      sec_snap_r       <= 6'd0;
      min_snap_r       <= 6'd0;
      hr_snap_r        <= 5'd0;
      mode_snap_r      <= 1'b0;
      blink_sel_snap_r <= 2'd0;
    end else begin
      first_r <= 1'b0;
      if (first_r || frame_wrap_s) begin
        sec_snap_r       <= i_seconds;
        min_snap_r       <= i_minutes;
        hr_snap_r        <= i_hours;
        mode_snap_r      <= i_mode_12h;
        blink_sel_snap_r <= i_blink_sel;
      end else begin
        sec_snap_r       <= sec_snap_r;
        min_snap_r       <= min_snap_r;
        hr_snap_r        <= hr_snap_r;
        mode_snap_r      <= mode_snap_r;
        blink_sel_snap_r <= blink_sel_snap_r;
      end
    end
  end

  // Field validity, 12h hour mapping, PM flag and BCD split.
  always_comb begin
    sec_valid_s = (sec_snap_r <= 6'd59);
    min_valid_s = (min_snap_r <= 6'd59);
    hr_valid_s  = (hr_snap_r <= 5'd23);
    if (mode_snap_r && (hr_snap_r == 5'd0)) begin
      hr_disp_s = 5'd12;
    end else if (mode_snap_r && (hr_snap_r > 5'd12)) begin
      hr_disp_s = hr_snap_r - 5'd12;
    end else begin
      hr_disp_s = hr_snap_r;
    end
    pm_s      = mode_snap_r && hr_valid_s && (hr_snap_r >= 5'd12);
    sec_bcd_s = to_bcd(sec_snap_r);
    min_bcd_s = to_bcd(min_snap_r);
    hr_bcd_s  = to_bcd({1'b0, hr_disp_s});
  end

  // Segment pattern and digit enable for the digit currently being scanned.
  always_comb begin
    raw_seg_s = SEG_BLANK;
    field_s   = FIELD_NONE;
    dig_s     = 6'b000000;
    case (idx_r)
      3'd0: begin
        field_s   = FIELD_SEC;
        dig_s     = 6'b000001;
        raw_seg_s = sec_valid_s ? seg_of_digit(sec_bcd_s[3:0]) : SEG_DASH;
      end
      3'd1: begin
        field_s   = FIELD_SEC;
        dig_s     = 6'b000010;
        raw_seg_s = sec_valid_s ? seg_of_digit(sec_bcd_s[7:4]) : SEG_DASH;
      end
      3'd2: begin
        field_s   = FIELD_MIN;
        dig_s     = 6'b000100;
        raw_seg_s = min_valid_s ? seg_of_digit(min_bcd_s[3:0]) : SEG_DASH;
      end
      3'd3: begin
        field_s   = FIELD_MIN;
        dig_s     = 6'b001000;
        raw_seg_s = min_valid_s ? seg_of_digit(min_bcd_s[7:4]) : SEG_DASH;
      end
      3'd4: begin
        field_s   = FIELD_HR;
        dig_s     = 6'b010000;
        raw_seg_s = hr_valid_s ? seg_of_digit(hr_bcd_s[3:0]) : SEG_DASH;
      end
      3'd5: begin
        field_s = FIELD_HR;
        dig_s   = 6'b100000;
        if (!hr_valid_s) begin
          raw_seg_s = SEG_DASH;
        end else if (mode_snap_r && (hr_bcd_s[7:4] == 4'd0)) begin
          raw_seg_s = SEG_BLANK;
        end else begin
          raw_seg_s = seg_of_digit(hr_bcd_s[7:4]);
        end
      end
      default: begin
        field_s   = FIELD_NONE;
        dig_s     = 6'b000000;
        raw_seg_s = SEG_BLANK;
      end
    endcase
    if (!blink_vis_r && (blink_sel_snap_r != FIELD_NONE) && (blink_sel_snap_r == field_s)) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = raw_seg_s;
    end
  end

  // Registered pin drive with polarity applied.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_seg <= SEG_POL;
      o_dig <= DIG_POL;
      o_pm  <= 1'b0;
    end else begin
      if (i_en) begin
        o_seg <= seg_s ^ SEG_POL;
        o_dig <= dig_s ^ DIG_POL;
      end else begin
        o_seg <= SEG_POL;
        o_dig <= DIG_POL;
      end
      o_pm <= pm_s;
    end
  end

endmodule

// File: tb/tb_clock_7seg_scan_driver.sv
// Directed bench for clock_7seg_scan_driver (SCAN_DIV=4, BLINK_DIV=16), with an
// active-high and an active-low instance sharing the same stimulus.
module tb_clock_7seg_scan_driver;

  typedef struct packed {
    logic [5:0]      s;
    logic [5:0]      m;
    logic [4:0]      h;
    logic            md;
    logic [5:0][6:0] seg;  // seg[k] = expected pattern of digit k
    logic            pm;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       mode;
  logic [1:0] bsel;
  logic [6:0] seg;
  logic [5:0] dig;
  logic       pm;
  logic [6:0] seg_al;
  logic [5:0] dig_al;
  logic       pm_al;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  clock_7seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_seconds(sec), .i_minutes(min),
    .i_hours(hr), .i_mode_12h(mode), .i_blink_sel(bsel), .o_seg(seg), .o_dig(dig), .o_pm(pm));

  clock_7seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_al (
    .i_clk(clk), .i_reset_n(reset_n), .i_en(en), .i_seconds(sec), .i_minutes(min),
    .i_hours(hr), .i_mode_12h(mode), .i_blink_sel(bsel), .o_seg(seg_al), .o_dig(dig_al), .o_pm(pm_al));

  // cyc counts edges since reset release; the output at edge n shows digit ((n-1)/4)%6
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic to_boundary();
    while (cyc % 24 != 0) tick();
  endtask

  task automatic apply(input vec_t v);
    sec  = v.s;
    min  = v.m;
    hr   = v.h;
    mode = v.md;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    sec = 6'd7; min = 6'd45; hr = 5'd13; mode = 1'b1; bsel = 2'd0; en = 1'b1;
    repeat (3) tick();
    checks++; if (seg !== 7'h00) begin errors++; $display("FAIL reset_seg: got %h exp 00", seg); end
    checks++; if (dig !== 6'h00) begin errors++; $display("FAIL reset_dig: got %h exp 00", dig); end
    checks++; if (pm !== 1'b0) begin errors++; $display("FAIL reset_pm: got %b exp 0", pm); end
    checks++; if (seg_al !== 7'h7F) begin errors++; $display("FAIL reset_seg_al: got %h exp 7f", seg_al); end
    checks++; if (dig_al !== 6'h3F) begin errors++; $display("FAIL reset_dig_al: got %h exp 3f", dig_al); end
    checks++; if (pm_al !== 1'b0) begin errors++; $display("FAIL reset_pm_al: got %b exp 0", pm_al); end
    reset_n = 1'b1;
    cyc = 0;
    tick();
    checks++; if (dig !== 6'h01) begin errors++; $display("FAIL first_dig: got %h exp 01", dig); end
    checks++; if (dig_al !== 6'h3E) begin errors++; $display("FAIL first_dig_al: got %h exp 3e", dig_al); end
  endtask

  task automatic test_display();
    vec_t tab [9];
    int d;
    logic [2:0] di;
    logic [5:0] oh;
    logic [6:0] es;
    tab = '{
      '{6'd7,  6'd45, 5'd13, 1'b0, {7'h06, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h07}, 1'b0},
      '{6'd7,  6'd45, 5'd13, 1'b1, {7'h00, 7'h06, 7'h66, 7'h6D, 7'h3F, 7'h07}, 1'b1},
      '{6'd7,  6'd45, 5'd0,  1'b1, {7'h06, 7'h5B, 7'h66, 7'h6D, 7'h3F, 7'h07}, 1'b0},
      '{6'd0,  6'd0,  5'd0,  1'b0, {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1'b0},
      '{6'd59, 6'd59, 5'd12, 1'b1, {7'h06, 7'h5B, 7'h6D, 7'h6F, 7'h6D, 7'h6F}, 1'b1},
      '{6'd38, 6'd21, 5'd23, 1'b1, {7'h06, 7'h06, 7'h5B, 7'h06, 7'h4F, 7'h7F}, 1'b1},
      '{6'd26, 6'd10, 5'd11, 1'b1, {7'h06, 7'h06, 7'h06, 7'h3F, 7'h5B, 7'h7D}, 1'b0},
      '{6'd42, 6'd37, 5'd9,  1'b1, {7'h00, 7'h6F, 7'h4F, 7'h07, 7'h66, 7'h5B}, 1'b0},
      '{6'd51, 6'd8,  5'd23, 1'b0, {7'h5B, 7'h4F, 7'h3F, 7'h7F, 7'h6D, 7'h06}, 1'b0}
    };
    bsel = 2'd0;
    for (int v = 0; v < 9; v++) begin
      apply(tab[v]);
      to_boundary();
      repeat (24) tick();
      for (int n = 0; n < 24; n++) begin
        tick();
        d = ((cyc - 1) / 4) % 6;
        di = 3'(d);
        oh = 6'b000001 << di;
        es = tab[v].seg[di];
        checks++; if (dig !== oh) begin errors++; $display("FAIL display_dig vec %0d cyc %0d: got %h exp %h", v, cyc, dig, oh); end
        checks++; if (seg !== es) begin errors++; $display("FAIL display_seg vec %0d digit %0d: got %h exp %h", v, d, seg, es); end
        checks++; if (pm !== tab[v].pm) begin errors++; $display("FAIL display_pm vec %0d: got %b exp %b", v, pm, tab[v].pm); end
        checks++; if (seg_al !== ~es || dig_al !== ~oh) begin
          errors++; $display("FAIL display_al vec %0d digit %0d: got %h/%h exp %h/%h", v, d, seg_al, dig_al, ~es, ~oh);
        end
      end
    end
  endtask

  task automatic test_invalid();
    vec_t tab [4];
    int d;
    logic [2:0] di;
    logic [6:0] es;
    tab = '{
      '{6'd60, 6'd45, 5'd24, 1'b1, {7'h40, 7'h40, 7'h66, 7'h6D, 7'h40, 7'h40}, 1'b0},
      '{6'd59, 6'd60, 5'd23, 1'b0, {7'h5B, 7'h4F, 7'h40, 7'h40, 7'h6D, 7'h6F}, 1'b0},
      '{6'd63, 6'd63, 5'd31, 1'b1, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b0},
      '{6'd0,  6'd59, 5'd24, 1'b0, {7'h40, 7'h40, 7'h6D, 7'h6F, 7'h3F, 7'h3F}, 1'b0}
    };
    bsel = 2'd0;
    for (int v = 0; v < 4; v++) begin
      apply(tab[v]);
      to_boundary();
      repeat (24) tick();
      for (int n = 0; n < 24; n++) begin
        tick();
        d = ((cyc - 1) / 4) % 6;
        di = 3'(d);
        es = tab[v].seg[di];
        checks++; if (seg !== es) begin errors++; $display("FAIL invalid_seg vec %0d digit %0d: got %h exp %h", v, d, seg, es); end
        checks++; if (pm !== 1'b0) begin errors++; $display("FAIL invalid_pm vec %0d: got %b exp 0", v, pm); end
      end
    end
  endtask

  task automatic test_midframe_change();
    logic [5:0][6:0] old_seg;
    logic [5:0][6:0] new_seg;
    int d;
    logic [2:0] di;
    old_seg = {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    new_seg = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h6F};
    sec = 6'd0; min = 6'd0; hr = 5'd12; mode = 1'b0; bsel = 2'd0;
    to_boundary();
    repeat (24) tick();
    for (int n = 0; n < 24; n++) begin
      if (n == 9) begin
        sec = 6'd59; min = 6'd59; hr = 5'd23;
      end
      tick();
      d = ((cyc - 1) / 4) % 6;
      di = 3'(d);
      checks++; if (seg !== old_seg[di]) begin errors++; $display("FAIL midframe_old digit %0d: got %h exp %h", d, seg, old_seg[di]); end
    end
    for (int n = 0; n < 24; n++) begin
      tick();
      d = ((cyc - 1) / 4) % 6;
      di = 3'(d);
      checks++; if (seg !== new_seg[di]) begin errors++; $display("FAIL midframe_new digit %0d: got %h exp %h", d, seg, new_seg[di]); end
    end
  endtask

  task automatic test_blink();
    logic [5:0][6:0] base;
    int d;
    int field;
    logic [2:0] di;
    logic [5:0] oh;
    logic [6:0] es;
    base = {7'h06, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h07};
    sec = 6'd7; min = 6'd45; hr = 5'd13; mode = 1'b0;
    for (int sel = 1; sel <= 3; sel++) begin
      bsel = 2'(sel);
      to_boundary();
      repeat (24) tick();
      for (int n = 0; n < 48; n++) begin
        tick();
        d = ((cyc - 1) / 4) % 6;
        di = 3'(d);
        oh = 6'b000001 << di;
        field = (d < 2) ? 3 : ((d < 4) ? 2 : 1);
        es = ((((cyc - 1) / 16) % 2 == 1) && (field == sel)) ? 7'h00 : base[di];
        checks++; if (seg !== es) begin errors++; $display("FAIL blink_seg sel %0d cyc %0d digit %0d: got %h exp %h", sel, cyc, d, seg, es); end
        checks++; if (dig !== oh) begin errors++; $display("FAIL blink_dig sel %0d cyc %0d: got %h exp %h", sel, cyc, dig, oh); end
      end
    end
    bsel = 2'd0;
  endtask

  task automatic test_enable();
    logic [5:0][6:0] base;
    int d;
    logic [2:0] di;
    logic [5:0] oh;
    base = {7'h06, 7'h4F, 7'h66, 7'h6D, 7'h3F, 7'h07};
    sec = 6'd7; min = 6'd45; hr = 5'd13; mode = 1'b0; bsel = 2'd0;
    to_boundary();
    repeat (24) tick();
    en = 1'b0;
    for (int n = 0; n < 24; n++) begin
      tick();
      checks++; if (dig !== 6'h00 || seg !== 7'h00) begin errors++; $display("FAIL disabled cyc %0d: got %h/%h exp 00/00", cyc, seg, dig); end
      checks++; if (dig_al !== 6'h3F || seg_al !== 7'h7F) begin errors++; $display("FAIL disabled_al cyc %0d: got %h/%h exp 7f/3f", cyc, seg_al, dig_al); end
    end
    en = 1'b1;
    for (int n = 0; n < 24; n++) begin
      tick();
      d = ((cyc - 1) / 4) % 6;
      di = 3'(d);
      oh = 6'b000001 << di;
      checks++; if (dig !== oh) begin errors++; $display("FAIL resume_dig cyc %0d: got %h exp %h", cyc, dig, oh); end
      checks++; if (seg !== base[di]) begin errors++; $display("FAIL resume_seg digit %0d: got %h exp %h", d, seg, base[di]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [5:0][6:0] new_seg;
    int d;
    logic [2:0] di;
    logic [5:0] oh;
    new_seg = {7'h3F, 7'h6F, 7'h4F, 7'h3F, 7'h06, 7'h6D};
    sec = 6'd7; min = 6'd45; hr = 5'd13; mode = 1'b1; bsel = 2'd0; en = 1'b1;
    to_boundary();
    repeat (24) tick();
    repeat (13) tick();
    checks++; if (pm !== 1'b1) begin errors++; $display("FAIL prereset_pm: got %b exp 1", pm); end
    reset_n = 1'b0;
    sec = 6'd15; min = 6'd30; hr = 5'd9; mode = 1'b0;
    tick();
    checks++; if (seg !== 7'h00 || dig !== 6'h00) begin errors++; $display("FAIL midreset_out: got %h/%h exp 00/00", seg, dig); end
    checks++; if (pm !== 1'b0) begin errors++; $display("FAIL midreset_pm: got %b exp 0", pm); end
    checks++; if (seg_al !== 7'h7F || dig_al !== 6'h3F) begin errors++; $display("FAIL midreset_al: got %h/%h exp 7f/3f", seg_al, dig_al); end
    reset_n = 1'b1;
    cyc = 0;
    tick();
    checks++; if (dig !== 6'h01) begin errors++; $display("FAIL postreset_dig: got %h exp 01", dig); end
    for (int n = 2; n <= 24; n++) begin
      tick();
      d = ((cyc - 1) / 4) % 6;
      di = 3'(d);
      oh = 6'b000001 << di;
      checks++; if (dig !== oh) begin errors++; $display("FAIL postreset_scan cyc %0d: got %h exp %h", cyc, dig, oh); end
      checks++; if (seg !== new_seg[di]) begin errors++; $display("FAIL postreset_seg digit %0d: got %h exp %h", d, seg, new_seg[di]); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    en = 1'b1;
    sec = 6'd0; min = 6'd0; hr = 5'd0; mode = 1'b0; bsel = 2'd0;
    test_reset();
    test_display();
    test_invalid();
    test_midframe_change();
    test_blink();
    test_enable();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
